// File: rtl/id_run_stats.sv
// Groups consecutive identifier hits into runs, keeps hit/run statistics and
// reports each finished run through a one-entry valid/ready buffer.
// Build option: define ID_RUN_STATS_SAT_EN to make hit_cnt/run_len saturate instead of wrap.
module id_run_stats #(
    parameter int CNT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             char_valid,
    input  logic             id_hit,
    input  logic             clr,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [LEN_W-1:0] run_len,
    output logic [LEN_W-1:0] max_run,
    output logic             evt_valid,
    output logic [LEN_W-1:0] evt_len,
    output logic [7:0]       evt_last,
    input  logic             evt_ready,
    output logic             ovf
);

    // state | meaning
    // IDLE  | no run in progress, run_len = 0
    // RUN   | at least one hit seen since the last miss
    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;
    logic             sampled, start, extend, run_end, accept, load;
    logic [7:0]       cap_char;
    logic [LEN_W-1:0] len_inc, len_nxt;
    logic [CNT_W-1:0] cnt_inc;

    assign sampled = char_valid & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= IDLE;
        else if (clr) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sampled && id_hit)  state_nxt = RUN;
            RUN:     if (sampled && !id_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        extend  = 1'b0;
        run_end = 1'b0;
        case (state)
            IDLE: start = sampled & id_hit;
            RUN: begin
                extend  = sampled & id_hit;
                run_end = sampled & ~id_hit;
            end
            default: ;
        endcase
    end

`ifdef ID_RUN_STATS_SAT_EN
    assign len_inc = (&run_len) ? run_len : run_len + LEN_W'(1);
    assign cnt_inc = (&hit_cnt) ? hit_cnt : hit_cnt + CNT_W'(1);
`else
    assign len_inc = run_len + LEN_W'(1);
    assign cnt_inc = hit_cnt + CNT_W'(1);
`endif

    assign len_nxt = start ? LEN_W'(1) : len_inc;
    assign accept  = evt_valid & evt_ready;
    // A finishing run may take the slot only if it is free or freed on this edge.
    assign load    = run_end & (~evt_valid | evt_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            run_len   <= '0;
            max_run   <= '0;
            cap_char  <= '0;
            evt_valid <= 1'b0;
            evt_len   <= '0;
            evt_last  <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            hit_cnt   <= '0;
            run_len   <= '0;
            max_run   <= '0;
            cap_char  <= '0;
            evt_valid <= 1'b0;
            evt_len   <= '0;
            evt_last  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (sampled && id_hit) begin
                hit_cnt  <= cnt_inc;
                cap_char <= char;
            end
            if (start || extend) begin
                run_len <= len_nxt;
                if (len_nxt > max_run) max_run <= len_nxt;
            end else if (run_end) begin
                run_len <= '0;
            end
            if (load) begin
                evt_valid <= 1'b1;
                evt_len   <= run_len;
                evt_last  <= cap_char;
            end else if (run_end) begin
                ovf <= 1'b1;
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_run_stats.sv
// Bench for id_run_stats: a default-width instance and a narrow instance (LEN_W=3, CNT_W=5)
// share one stimulus stream and are checked every cycle against a run-level model.
module tb_id_run_stats;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] char;
    logic       char_valid, id_hit, clr, evt_ready;

    logic [15:0] a_hit_cnt;
    logic [7:0]  a_run_len, a_max_run, a_evt_len, a_evt_last;
    logic        a_evt_valid, a_ovf;
    logic [4:0]  b_hit_cnt;
    logic [2:0]  b_run_len, b_max_run, b_evt_len;
    logic [7:0]  b_evt_last;
    logic        b_evt_valid, b_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // run-level reference model, one slot per instance
    int lw[2] = '{8, 3};
    int cw[2] = '{16, 5};
    bit m_in_run[2];
    int m_rl[2], m_hc[2], m_mr[2], m_last[2];
    bit m_ev[2], m_ovf[2];
    int m_ev_len[2], m_ev_last[2];

    always #5 clk = ~clk;

    id_run_stats #(.CNT_W(16), .LEN_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .char(char), .char_valid(char_valid), .id_hit(id_hit),
        .clr(clr), .hit_cnt(a_hit_cnt), .run_len(a_run_len), .max_run(a_max_run),
        .evt_valid(a_evt_valid), .evt_len(a_evt_len), .evt_last(a_evt_last),
        .evt_ready(evt_ready), .ovf(a_ovf)
    );

    id_run_stats #(.CNT_W(5), .LEN_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .char(char), .char_valid(char_valid), .id_hit(id_hit),
        .clr(clr), .hit_cnt(b_hit_cnt), .run_len(b_run_len), .max_run(b_max_run),
        .evt_valid(b_evt_valid), .evt_len(b_evt_len), .evt_last(b_evt_last),
        .evt_ready(evt_ready), .ovf(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int adv(input int v, input int w);
`ifdef ID_RUN_STATS_SAT_EN
        return (v == (1 << w) - 1) ? v : v + 1;
`else
        return (v + 1) % (1 << w);
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_in_run[i] = 0; m_rl[i] = 0; m_hc[i] = 0; m_mr[i] = 0; m_last[i] = 0;
            m_ev[i] = 0; m_ovf[i] = 0; m_ev_len[i] = 0; m_ev_last[i] = 0;
        end
    endfunction

    function automatic void model_step(input bit cv, input bit h, input int c, input bit cl, input bit rdy);
        for (int i = 0; i < 2; i++) begin
            bit ended = 0;
            int end_len = 0;
            if (cl) begin
                m_in_run[i] = 0; m_rl[i] = 0; m_hc[i] = 0; m_mr[i] = 0; m_last[i] = 0;
                m_ev[i] = 0; m_ovf[i] = 0; m_ev_len[i] = 0; m_ev_last[i] = 0;
                continue;
            end
            if (cv) begin
                if (h) begin
                    m_hc[i] = adv(m_hc[i], cw[i]);
                    m_rl[i] = m_in_run[i] ? adv(m_rl[i], lw[i]) : 1;
                    m_in_run[i] = 1;
                    m_last[i] = c;
                    if (m_rl[i] > m_mr[i]) m_mr[i] = m_rl[i];
                end else if (m_in_run[i]) begin
                    ended = 1;
                    end_len = m_rl[i];
                    m_in_run[i] = 0;
                    m_rl[i] = 0;
                end
            end
            if (ended) begin
                if (!m_ev[i] || rdy) begin
                    m_ev[i] = 1; m_ev_len[i] = end_len; m_ev_last[i] = m_last[i];
                end else begin
                    m_ovf[i] = 1;
                end
            end else if (m_ev[i] && rdy) begin
                m_ev[i] = 0;
            end
        end
    endfunction

    task automatic compare_all();
        chk("a.hit_cnt",   32'(a_hit_cnt),   m_hc[0]);
        chk("a.run_len",   32'(a_run_len),   m_rl[0]);
        chk("a.max_run",   32'(a_max_run),   m_mr[0]);
        chk("a.evt_valid", 32'(a_evt_valid), 32'(m_ev[0]));
        chk("a.ovf",       32'(a_ovf),       32'(m_ovf[0]));
        if (m_ev[0]) begin
            chk("a.evt_len",  32'(a_evt_len),  m_ev_len[0]);
            chk("a.evt_last", 32'(a_evt_last), m_ev_last[0]);
        end
        chk("b.hit_cnt",   32'(b_hit_cnt),   m_hc[1]);
        chk("b.run_len",   32'(b_run_len),   m_rl[1]);
        chk("b.max_run",   32'(b_max_run),   m_mr[1]);
        chk("b.evt_valid", 32'(b_evt_valid), 32'(m_ev[1]));
        chk("b.ovf",       32'(b_ovf),       32'(m_ovf[1]));
        if (m_ev[1]) begin
            chk("b.evt_len",  32'(b_evt_len),  m_ev_len[1]);
            chk("b.evt_last", 32'(b_evt_last), m_ev_last[1]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".hit_cnt"},   32'(a_hit_cnt),   0);
        chk({tag, ".run_len"},   32'(a_run_len),   0);
        chk({tag, ".max_run"},   32'(a_max_run),   0);
        chk({tag, ".evt_valid"}, 32'(a_evt_valid), 0);
        chk({tag, ".evt_len"},   32'(a_evt_len),   0);
        chk({tag, ".evt_last"},  32'(a_evt_last),  0);
        chk({tag, ".ovf"},       32'(a_ovf),       0);
        chk({tag, ".b_run_len"}, 32'(b_run_len),   0);
    endtask

    // Drive one cycle's inputs just after a falling edge, clock it, check on the next falling edge.
    task automatic cycle(input bit cv, input bit h, input logic [7:0] c, input bit cl, input bit rdy);
        char = c; char_valid = cv; id_hit = h; clr = cl; evt_ready = rdy;
        @(posedge clk);
        model_step(cv, h, int'(c), cl, rdy);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; char = '0; char_valid = 0; id_hit = 0; clr = 0; evt_ready = 0;
        model_reset();
        #1;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // basic run: '%' miss, "ab1" hits, '2' miss
        cycle(1, 0, "%", 0, 0);
        cycle(1, 1, "a", 0, 0);
        cycle(1, 1, "b", 0, 0);
        cycle(1, 1, "1", 0, 0);
        cycle(1, 0, "2", 0, 0);
        chk("basic.evt_valid", 32'(a_evt_valid), 1);
        chk("basic.evt_len",   32'(a_evt_len),   3);
        chk("basic.evt_last",  32'(a_evt_last),  49);
        chk("basic.hit_cnt",   32'(a_hit_cnt),   3);
        chk("basic.max_run",   32'(a_max_run),   3);
        chk("basic.run_len",   32'(a_run_len),   0);
        cycle(1, 1, "z", 1, 0);

        // backpressure: runs of 2 and 4 with nobody accepting
        for (int i = 0; i < 2; i++) cycle(1, 1, 8'(8'h41 + i), 0, 0);
        cycle(1, 0, " ", 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h61 + i), 0, 0);
        cycle(1, 0, " ", 0, 0);
        chk("bp.evt_len",  32'(a_evt_len),  2);
        chk("bp.evt_last", 32'(a_evt_last), 8'h42);
        chk("bp.ovf",      32'(a_ovf),      1);
        chk("bp.max_run",  32'(a_max_run),  4);
        chk("bp.hit_cnt",  32'(a_hit_cnt),  6);
        cycle(0, 0, 0, 1, 0);
        chk("clr.ovf", 32'(a_ovf), 0);

        // accept and new run end on the same edge
        cycle(1, 1, "p", 0, 0);
        cycle(1, 1, "q", 0, 0);
        cycle(1, 0, ";", 0, 0);
        cycle(1, 1, "r", 0, 0);
        cycle(1, 0, ";", 0, 1);
        chk("simul.evt_valid", 32'(a_evt_valid), 1);
        chk("simul.evt_len",   32'(a_evt_len),   1);
        chk("simul.evt_last",  32'(a_evt_last),  8'h72);
        chk("simul.ovf",       32'(a_ovf),       0);
        cycle(0, 0, 0, 0, 1);
        chk("simul.drain", 32'(a_evt_valid), 0);
        cycle(1, 0, 0, 1, 0);

        // run spans char_valid gaps
        cycle(1, 1, "x", 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, "!", 0, 0);
        cycle(1, 1, "y", 0, 0);
        cycle(1, 0, ".", 0, 0);
        chk("gap.evt_len", 32'(a_evt_len), 2);
        chk("gap.hit_cnt", 32'(a_hit_cnt), 2);
        cycle(1, 0, 0, 1, 1);

        // narrow instance: 9 hits overflow a 3-bit run length
        for (int i = 0; i < 9; i++) cycle(1, 1, 8'(8'h30 + i), 0, 0);
        cycle(1, 0, " ", 0, 0);
`ifdef ID_RUN_STATS_SAT_EN
        chk("width.evt_len", 32'(b_evt_len), 7);
`else
        chk("width.evt_len", 32'(b_evt_len), 1);
`endif
        chk("width.max_run", 32'(b_max_run), 7);
        chk("width.a_evt_len", 32'(a_evt_len), 9);
        cycle(1, 0, 0, 1, 0);

        // asynchronous reset in the middle of a run
        for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'h6b + i), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1, 0, "-", 0, 1);
        chk("rst.no_evt", 32'(a_evt_valid), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit cv  = ($urandom_range(0, 9) < 8);
            bit h   = ($urandom_range(0, 9) < 7);
            bit cl  = ($urandom_range(0, 199) == 0);
            bit rdy = ($urandom_range(0, 2) == 0);
            cycle(cv, h, 8'($urandom), cl, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
